// File: rtl/fp_wb_pkg.sv
// rtl/fp_wb_pkg.sv - shared widths, zero-register index and write-port record for the FP writeback arbiter
package fp_wb_pkg;

  localparam int FP_ADDR_W = 5;
  localparam int FP_DATA_W = 32;
  localparam logic [FP_ADDR_W-1:0] FP_ZERO_REG = 5'd22;

  typedef struct packed {
    logic                 we;
    logic [FP_ADDR_W-1:0] addr;
    logic [FP_DATA_W-1:0] data;
  } fp_wr_t;

endpackage

// File: rtl/fp_rr_pick.sv
// rtl/fp_rr_pick.sv - combinational round-robin picker: first set valid bit at or after start, wrapping
module fp_rr_pick #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic             found
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(start) + k) % N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_writeback_arbiter.sv
// rtl/fp_writeback_arbiter.sv - two-port round-robin FP register-file writeback arbiter
// Optional: FP_ZERO_REG_PROTECT_EN consumes writes to FP_ZERO_REG without asserting a write enable.
module fp_writeback_arbiter
  import fp_wb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = FP_ADDR_W,
  parameter int DATA_W = FP_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    f_WE,
  output logic [ADDR_W-1:0]       f_write_addr,
  output logic [DATA_W-1:0]       f_data,
  output logic                    f_WE2,
  output logic [ADDR_W-1:0]       f_write_addr2,
  output logic [DATA_W-1:0]       f_data2,
  output logic [31:0]             pend_mask
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              f_we_q, f_we_d, f_we2_q, f_we2_d;
  logic [ADDR_W-1:0] f_addr_q, f_addr_d, f_addr2_q, f_addr2_d;
  logic [DATA_W-1:0] f_data_q, f_data_d, f_data2_q, f_data2_d;

  logic [N_REQ-1:0]  grant_a, grant_b, valid_b, same_addr, last_grant;
  logic              found_a, found_b, write_a, write_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;

  fp_rr_pick #(.N(N_REQ)) u_pick_a (
    .valid (req_valid),
    .start (rr_ptr_q),
    .grant (grant_a),
    .found (found_a)
  );

  always_comb begin
    addr_a = '0;
    data_a = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_a[i]) begin
        addr_a = req_addr[i*ADDR_W +: ADDR_W];
        data_a = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Same-register requesters wait a cycle so both ports never hit one register.
  always_comb begin
    same_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      same_addr[i] = found_a && (req_addr[i*ADDR_W +: ADDR_W] == addr_a);
    end
    valid_b = req_valid & ~grant_a & ~same_addr;
  end

  fp_rr_pick #(.N(N_REQ)) u_pick_b (
    .valid (valid_b),
    .start (rr_ptr_q),
    .grant (grant_b),
    .found (found_b)
  );

  always_comb begin
    addr_b = '0;
    data_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_b[i]) begin
        addr_b = req_addr[i*ADDR_W +: ADDR_W];
        data_b = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = rst ? '0 : (grant_a | grant_b);

`ifdef FP_ZERO_REG_PROTECT_EN
  assign write_a = found_a && (addr_a != ADDR_W'(FP_ZERO_REG));
  assign write_b = found_b && (addr_b != ADDR_W'(FP_ZERO_REG));
`else
  assign write_a = found_a;
  assign write_b = found_b;
`endif

  always_comb begin
    last_grant = found_b ? grant_b : grant_a;
    rr_ptr_d   = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (last_grant[i]) rr_ptr_d = PTR_W'((i + 1) % N_REQ);
    end
    f_we_d    = write_a;
    f_addr_d  = found_a ? addr_a : f_addr_q;
    f_data_d  = found_a ? data_a : f_data_q;
    f_we2_d   = write_b;
    f_addr2_d = found_b ? addr_b : f_addr2_q;
    f_data2_d = found_b ? data_b : f_data2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      f_we_q    <= 1'b0;
      f_addr_q  <= '0;
      f_data_q  <= '0;
      f_we2_q   <= 1'b0;
      f_addr2_q <= '0;
      f_data2_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      f_we_q    <= f_we_d;
      f_addr_q  <= f_addr_d;
      f_data_q  <= f_data_d;
      f_we2_q   <= f_we2_d;
      f_addr2_q <= f_addr2_d;
      f_data2_q <= f_data2_d;
    end
  end

  assign f_WE          = f_we_q;
  assign f_write_addr  = f_addr_q;
  assign f_data        = f_data_q;
  assign f_WE2         = f_we2_q;
  assign f_write_addr2 = f_addr2_q;
  assign f_data2       = f_data2_q;

  assign pend_mask = (f_we_q  ? (32'd1 << f_addr_q)  : 32'd0)
                   | (f_we2_q ? (32'd1 << f_addr2_q) : 32'd0);

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// tb/tb_fp_writeback_arbiter.sv - directed scoreboard bench for fp_writeback_arbiter
module tb_fp_writeback_arbiter;
  import fp_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        f_WE, f_WE2;
  logic [4:0]  f_write_addr, f_write_addr2;
  logic [31:0] f_data, f_data2, pend_mask;

  int checks = 0;
  int errors = 0;

  fp_wr_t      q1[$];
  fp_wr_t      q2[$];
  logic [31:0] qp[$];

  always #5 clk = ~clk;

  fp_writeback_arbiter #(.N_REQ(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .f_WE          (f_WE),
    .f_write_addr  (f_write_addr),
    .f_data        (f_data),
    .f_WE2         (f_WE2),
    .f_write_addr2 (f_write_addr2),
    .f_data2       (f_data2),
    .pend_mask     (pend_mask)
  );

  function automatic fp_wr_t mk(input logic we, input logic [4:0] a, input logic [31:0] d);
    fp_wr_t w;
    w.we = we; w.addr = a; w.data = d;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  // Drive one cycle of stimulus, check the same-cycle grant, then check the registered ports.
  task automatic step(input string tag, input logic r, input logic [3:0] v, input logic [3:0] exp_ready,
                      input fp_wr_t e1, input fp_wr_t e2, input logic [31:0] exp_pend);
    fp_wr_t o1, o2;
    logic [31:0] op;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
    q1.push_back(e1);
    q2.push_back(e2);
    qp.push_back(exp_pend);
    @(posedge clk);
    #1;
    o1 = q1.pop_front();
    o2 = q2.pop_front();
    op = qp.pop_front();
    chk({tag, ".we1"}, 32'(f_WE), 32'(o1.we));
    if (o1.we) begin
      chk({tag, ".addr1"}, 32'(f_write_addr), 32'(o1.addr));
      chk({tag, ".data1"}, f_data, o1.data);
    end
    chk({tag, ".we2"}, 32'(f_WE2), 32'(o2.we));
    if (o2.we) begin
      chk({tag, ".addr2"}, 32'(f_write_addr2), 32'(o2.addr));
      chk({tag, ".data2"}, f_data2, o2.data);
    end
    chk({tag, ".pend"}, op === pend_mask ? 32'd1 : 32'd0, 32'd1);
    if (op !== pend_mask) $display("  pend_mask observed %h expected %h", pend_mask, op);
  endtask

  initial begin
    fp_wr_t idle;
    idle      = mk(1'b0, 5'd0, 32'd0);
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + i);

    // Reset held two cycles with every producer valid.
    step("rst0", 1'b1, 4'b1111, 4'b0000, idle, idle, 32'h0);
    step("rst1", 1'b1, 4'b1111, 4'b0000, idle, idle, 32'h0);
    chk("rst.addr1", 32'(f_write_addr), 32'd0);
    chk("rst.data2", f_data2, 32'd0);

    // Two distinct registers go out on both ports.
    set_req(0, 5'd3, 32'h4060_0000);
    set_req(2, 5'd5, 32'h3FA0_0000);
    step("dual", 1'b0, 4'b0101, 4'b0101,
         mk(1'b1, 5'd3, 32'h4060_0000), mk(1'b1, 5'd5, 32'h3FA0_0000), 32'h0000_0028);

    // Reset right after a grant drops the write and returns the pointer to 0.
    step("rstmid", 1'b1, 4'b1111, 4'b0000, idle, idle, 32'h0);

    // Same-address pair: req1 first, req3 next cycle on port 1.
    set_req(1, 5'd7, 32'h1111_1111);
    set_req(3, 5'd7, 32'h3333_3333);
    step("same0", 1'b0, 4'b1010, 4'b0010, mk(1'b1, 5'd7, 32'h1111_1111), idle, 32'h0000_0080);
    step("same1", 1'b0, 4'b1000, 4'b1000, mk(1'b1, 5'd7, 32'h3333_3333), idle, 32'h0000_0080);
    step("idle", 1'b0, 4'b0000, 4'b0000, idle, idle, 32'h0);
    chk("hold.addr1", 32'(f_write_addr), 32'd7);
    chk("hold.data1", f_data, 32'h3333_3333);

    // All four valid with distinct registers alternate between pairs.
    for (int i = 0; i < 4; i++) set_req(i, 5'(10 + i), 32'hD000_0000 + i);
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0)
        step($sformatf("rr%0d", c), 1'b0, 4'b1111, 4'b0011,
             mk(1'b1, 5'd10, 32'hD000_0000), mk(1'b1, 5'd11, 32'hD000_0001), 32'h0000_0C00);
      else
        step($sformatf("rr%0d", c), 1'b0, 4'b1111, 4'b1100,
             mk(1'b1, 5'd12, 32'hD000_0002), mk(1'b1, 5'd13, 32'hD000_0003), 32'h0000_3000);
    end

    // Zero register alongside a normal write.
    set_req(0, 5'd22, 32'h3F80_0000);
    set_req(1, 5'd4,  32'hC000_0000);
`ifdef FP_ZERO_REG_PROTECT_EN
    step("zreg", 1'b0, 4'b0011, 4'b0011,
         mk(1'b0, 5'd22, 32'h3F80_0000), mk(1'b1, 5'd4, 32'hC000_0000), 32'h0000_0010);
`else
    step("zreg", 1'b0, 4'b0011, 4'b0011,
         mk(1'b1, 5'd22, 32'h3F80_0000), mk(1'b1, 5'd4, 32'hC000_0000), 32'h0040_0010);
`endif

    // Pointer now 2: req2 leads, req1 shares its register and is skipped, req0 takes port 2.
    set_req(0, 5'd9, 32'h0000_0900);
    set_req(1, 5'd8, 32'h0000_0801);
    set_req(2, 5'd8, 32'h0000_0802);
    step("skip", 1'b0, 4'b0111, 4'b0101,
         mk(1'b1, 5'd8, 32'h0000_0802), mk(1'b1, 5'd9, 32'h0000_0900), 32'h0000_0300);
    step("skip2", 1'b0, 4'b0010, 4'b0010, mk(1'b1, 5'd8, 32'h0000_0801), idle, 32'h0000_0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
